// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: drives the serializer and muxes
// start, data, parity and stop bits onto a registered TX line.
module uart_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_data,
    input  logic             ser_done,
    output logic             sample,
    output logic             ser_en,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             SER_ERR
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA_ST,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_nxt;
    logic [1:0]    stop_cnt;
    logic          par_en_q;
    logic          par_bit_q;
    logic          last_stop;
    logic          accept;
    logic          data_exit;
    logic          line_val;

    assign bit_nxt   = bit_cnt + CW'(1);
    assign data_exit = ser_done || (bit_nxt == CW'(WIDTH));
    assign last_stop = (state == STOP) && (stop_cnt == 2'(STOP_BITS - 1));
    assign accept    = DATA_VALID && ((state == IDLE) || last_stop);

    always_comb begin
        sample   = !RST && accept;
        ser_en   = !RST && ((state == START) ||
                            ((state == DATA_ST) && !ser_done));
        line_val = 1'b1;
        unique case (state)
            IDLE:    line_val = 1'b1;
            START:   line_val = 1'b0;
            DATA_ST: line_val = ser_data;
            PARITY:  line_val = par_bit_q;
            STOP:    line_val = 1'b1;
            default: line_val = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
            SER_ERR   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
        end else begin
            // Line and BUSY both reflect the state one cycle late.
            TX_OUT  <= line_val;
            BUSY    <= (state != IDLE);
            SER_ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        par_en_q  <= PAR_EN;
                        par_bit_q <= (^DATA) ^ PAR_TYP;
                        state     <= START;
                    end
                end
                START: begin
                    bit_cnt <= '0;
                    state   <= DATA_ST;
                end
                DATA_ST: begin
                    bit_cnt <= bit_nxt;
                    if (data_exit) begin
                        bit_cnt  <= '0;
                        stop_cnt <= '0;
                        SER_ERR  <= !ser_done;
                        state    <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    stop_cnt <= '0;
                    state    <= STOP;
                end
                STOP: begin
                    if (last_stop) begin
                        stop_cnt <= '0;
                        if (accept) begin
                            par_en_q  <= PAR_EN;
                            par_bit_q <= (^DATA) ^ PAR_TYP;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
